multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/alu_decoder.sv | 25 ++
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32 control path and the ALU:
// ALU operation codes, major opcodes and the control FSM state encoding.
package riscv_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7_5 -> ALU operation map.
// Ports: funct3, funct7_5, is_r (R-type, enables sub) in; alu_op, unsupported out.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_r,
    output logic [3:0] alu_op,
    output logic       unsupported
);

    always_comb begin
        alu_op      = ALU_ADD;
        unsupported = 1'b0;
        unique case (1'b1)
            (funct3 == F3_ADD): alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            (funct3 == F3_XOR): alu_op = ALU_XOR;
            (funct3 == F3_OR):  alu_op = ALU_OR;
            (funct3 == F3_AND): alu_op = ALU_AND;
            default:            unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: instruction sequencing, memory handshake
// with wait timeout, and trap on unsupported instructions.
// Ports: clk, rst (async, active-high); opcode/funct3/funct7_5 from IR,
// zero from ALU, mem_ready from memory; datapath selects and strobes out,
// illegal (in TRAP) and state_dbg (current state encoding).
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] ALUop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       adr_src,
    output logic       pc_src,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout;
    logic [3:0]        dec_op;
    logic              dec_bad;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_r        (state == EXEC_R),
        .alu_op      (dec_op),
        .unsupported (dec_bad)
    );

    assign waiting   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeout   = !mem_ready && (wait_cnt == WAIT_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            // Any state change clears the count, which covers every
            // entry into a wait state.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (waiting && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ALUop      = ALU_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        adr_src    = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = TRAP;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:     state_next = dec_bad ? TRAP : EXEC_R;
                    OP_I:     state_next = dec_bad ? TRAP : EXEC_I;
                    OP_LOAD,
                    OP_STORE: state_next = MEM_ADDR;
                    OP_BRANCH: state_next = (funct3 == F3_BEQ) ? BRANCH : TRAP;
                    default:  state_next = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUop      = dec_op;
                alu_src_a  = 2'b10;
                state_next = WB_ALU;
            end
            EXEC_I: begin
                ALUop      = dec_op;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                state_next = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) begin
                    state_next = WB_MEM;
                end else if (timeout) begin
                    state_next = TRAP;
                end
            end
            MEM_WR: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = TRAP;
                end
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUop      = ALU_SUB;
                alu_src_a  = 2'b10;
                pc_src     = 1'b1;
                pc_write   = zero;
                state_next = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = TRAP;
            end
        endcase

        // Reset silences the FETCH memory request before any clock edge.
        if (rst) begin
            ALUop      = ALU_ADD;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            adr_src    = 1'b0;
            pc_src     = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction
// sequences compared cycle by cycle against hand-computed output vectors.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] ALUop;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write;
    logic       mem_to_reg, adr_src, pc_src, illegal;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .adr_src(adr_src), .pc_src(pc_src),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {state, ALUop, src_a, src_b, mr, mw, ir, pw, rw, m2r, adr, pcs, ill}
    logic [20:0] obs;
    assign obs = {state_dbg, ALUop, alu_src_a, alu_src_b, mem_read, mem_write,
                  ir_write, pc_write, reg_write, mem_to_reg, adr_src, pc_src,
                  illegal};

    localparam logic [20:0] RST_V   = {4'd0,  4'b0010, 2'b00, 2'b00, 9'b000000000};
    localparam logic [20:0] FET_RDY = {4'd0,  4'b0010, 2'b00, 2'b01, 9'b101100000};
    localparam logic [20:0] FET_NR  = {4'd0,  4'b0010, 2'b00, 2'b01, 9'b100000000};
    localparam logic [20:0] DEC     = {4'd1,  4'b0010, 2'b01, 2'b10, 9'b000000000};
    localparam logic [20:0] EXR_ADD = {4'd2,  4'b0010, 2'b10, 2'b00, 9'b000000000};
    localparam logic [20:0] EXR_SUB = {4'd2,  4'b0110, 2'b10, 2'b00, 9'b000000000};
    localparam logic [20:0] MADDR   = {4'd4,  4'b0010, 2'b10, 2'b10, 9'b000000000};
    localparam logic [20:0] MRD     = {4'd5,  4'b0010, 2'b00, 2'b00, 9'b100000100};
    localparam logic [20:0] MWR     = {4'd6,  4'b0010, 2'b00, 2'b00, 9'b010000100};
    localparam logic [20:0] WBA     = {4'd7,  4'b0010, 2'b00, 2'b00, 9'b000010000};
    localparam logic [20:0] WBM     = {4'd8,  4'b0010, 2'b00, 2'b00, 9'b000011000};
    localparam logic [20:0] BR1     = {4'd9,  4'b0110, 2'b10, 2'b00, 9'b000100010};
    localparam logic [20:0] BR0     = {4'd9,  4'b0110, 2'b10, 2'b00, 9'b000000010};
    localparam logic [20:0] TRP     = {4'd10, 4'b0010, 2'b00, 2'b00, 9'b000000001};

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== RST_V) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", obs, RST_V);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== RST_V) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", obs, RST_V);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== FET_RDY) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs, FET_RDY);
        end
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        logic [20:0] e [8];
        e = '{FET_RDY, DEC, EXR_ADD, WBA, FET_RDY, DEC, EXR_SUB, WBA};
        do_reset();
        opcode = 7'b0110011;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            funct7_5 = (i >= 4);
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL add_sub cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] opc [6];
        logic [2:0] f3 [6];
        logic [3:0] op [6];
        logic [20:0] e;
        opc = '{7'b0110011, 7'b0110011, 7'b0110011,
                7'b0010011, 7'b0010011, 7'b0010011};
        f3  = '{3'b100, 3'b110, 3'b111, 3'b000, 3'b100, 3'b111};
        op  = '{4'b0011, 4'b0001, 4'b0000, 4'b0010, 4'b0011, 4'b0000};
        do_reset();
        mem_ready = 1'b1;
        funct7_5 = 1'b1;
        for (int v = 0; v < 6; v++) begin
            opcode = opc[v];
            funct3 = f3[v];
            for (int c = 0; c < 4; c++) begin
                if (c == 0) e = FET_RDY;
                else if (c == 1) e = DEC;
                else if (c == 3) e = WBA;
                else if (v < 3) e = {4'd2, op[v], 2'b10, 2'b00, 9'b0};
                else e = {4'd3, op[v], 2'b10, 2'b10, 9'b0};
                #1;
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL alu_op v%0d cyc%0d: got %h want %h", v, c, obs, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_load();
        logic [20:0] e [9];
        logic rdy [9];
        e   = '{FET_RDY, DEC, MADDR, MRD, MRD, MRD, MRD, WBM, FET_RDY};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        opcode = 7'b0000011;
        funct3 = 3'b010;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL load cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store();
        logic [20:0] e [6];
        logic rdy [6];
        e   = '{FET_RDY, DEC, MADDR, MWR, MWR, FET_RDY};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        opcode = 7'b0100011;
        funct3 = 3'b010;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL store cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [20:0] e [8];
        e = '{FET_RDY, DEC, BR1, FET_RDY, DEC, BR0, FET_RDY, DEC};
        do_reset();
        opcode = 7'b1100011;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            zero = (i < 3);
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL branch cyc%0d: got %h want %h", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        logic [20:0] e;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            mem_ready = 1'b1;
            zero = 1'b1;
            funct7_5 = 1'b0;
            if (t == 0) begin
                opcode = 7'b1111111; funct3 = 3'b000;
            end else if (t == 1) begin
                opcode = 7'b0010011; funct3 = 3'b001;
            end else begin
                opcode = 7'b1100011; funct3 = 3'b001;
            end
            for (int i = 0; i < 22; i++) begin
                e = (i == 0) ? FET_RDY : (i == 1) ? DEC : TRP;
                #1;
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL trap t%0d cyc%0d: got %h want %h", t, i, obs, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_timeout();
        logic [20:0] e;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            e = (i < 16) ? FET_NR : TRP;
            #1;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fetch_timeout cyc%0d: got %h want %h", i, obs, e);
            end
            @(negedge clk);
        end
        do_reset();
        opcode = 7'b0110011;
        funct3 = 3'b000;
        for (int i = 0; i < 17; i++) begin
            mem_ready = (i >= 15);
            e = (i < 15) ? FET_NR : (i == 15) ? FET_RDY : DEC;
            #1;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fetch_last_ready cyc%0d: got %h want %h", i, obs, e);
            end
            @(negedge clk);
        end
        do_reset();
        opcode = 7'b0000011;
        for (int i = 0; i < 20; i++) begin
            mem_ready = (i < 3);
            e = (i == 0) ? FET_RDY : (i == 1) ? DEC : (i == 2) ? MADDR :
                (i < 19) ? MRD : TRP;
            #1;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL memrd_timeout cyc%0d: got %h want %h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wr();
        logic [20:0] e [4];
        e = '{FET_RDY, DEC, MADDR, MWR};
        do_reset();
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            #1;
            n_checks++;
            if (obs !== e[i]) begin
                n_fail++;
                $display("FAIL rst_wr_pre cyc%0d: got %h want %h", i, obs, e[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== RST_V) begin
            n_fail++;
            $display("FAIL rst_wr_async: got %h want %h", obs, RST_V);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== RST_V) begin
            n_fail++;
            $display("FAIL rst_wr_held: got %h want %h", obs, RST_V);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs !== FET_NR) begin
            n_fail++;
            $display("FAIL rst_wr_release: got %h want %h", obs, FET_NR);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_sub();
        test_alu_ops();
        test_load();
        test_store();
        test_branch();
        test_trap();
        test_timeout();
        test_reset_mid_wr();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
